// File: rtl/mult_acc_4bit_if.sv
// Term/result handshake bundle for mult_acc_4bit.
// The master drives the terms and consumes the result; the slave is the accumulator.
interface mult_acc_4bit_if #(
  parameter int ACC_W = 12
);
  logic             start;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, a, b, in_valid, out_ready,
    input  in_ready, acc, ovf, out_valid
  );

  modport slave (
    input  start, a, b, in_valid, out_ready,
    output in_ready, acc, ovf, out_valid
  );
endinterface

// File: rtl/mult_acc_4bit.sv
// Saturating multiply-accumulate over N_TERMS unsigned 4x4 products.
// Products are staged in a register and added one cycle later; the result is held until consumed.
module mult_acc_4bit #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic          clk,
  input  logic          rst,
  mult_acc_4bit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic [ACC_W:0] SUM_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [3:0]     CNT_LAST = 4'(N_TERMS - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [7:0]       r_prod;
  logic             r_prod_vld;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic [7:0]       w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;

  // r_in_ready is only ever high in ACCUM, so it alone qualifies acceptance
  assign w_accept = r_in_ready & bus.in_valid;
  assign w_prod   = {4'b0, bus.a} * {4'b0, bus.b};
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, r_prod};
  assign w_sat    = w_sum > SUM_MAX;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.acc       = r_acc;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_prod_vld  <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_prod_vld <= w_accept;
      if (w_accept) r_prod <= w_prod;

      if (r_prod_vld) begin
        if (w_sat) begin
          r_acc <= SUM_MAX[ACC_W-1:0];
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
        end
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == CNT_LAST) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        // the last product lands in acc on this edge
        DRAIN: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_ready_in_accum: assert property (@(posedge clk) disable iff (rst)
    r_in_ready |-> (r_state == ACCUM));
  a_valid_in_done: assert property (@(posedge clk) disable iff (rst)
    r_out_valid == (r_state == DONE));
  a_ovf_saturated: assert property (@(posedge clk) disable iff (rst)
    r_ovf |-> (r_acc == SUM_MAX[ACC_W-1:0]));
endmodule
